seq_match_monitor: RTL and testbench

Synthesizable in-order pattern monitor for the user-project output bus. It watches a WIDTH-bit observation bus, gated by a ready flag, and waits for a programmed list of expected values to appear in order. It reports per-entry match pulses and a final pass/fail verdict, so silicon and gate-level runs can self-check FPU result streams without a host.

---
 rtl/seq_match_monitor_pkg.sv | 16 +
 rtl/seq_match_exp_mem.sv | 31 +++
 rtl/seq_match_monitor.sv | 156 +++++++++++++++
 tb/tb_seq_match_monitor.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_match_monitor_pkg.sv
// Shared definitions for seq_match_monitor: the FSM state type, its encoding width,
// and the width of the per-entry stable counter.
package seq_match_monitor_pkg;

  localparam int STATE_W = 3;
  localparam int STAB_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    ARMED,
    CHECK,
    PASS,
    FAIL
  } state_t;

endpackage

// File: rtl/seq_match_exp_mem.sv
// Expected-value/mask register file: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a loaded list survives restarts.
module seq_match_exp_mem #(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [WIDTH-1:0] i_wr_mask,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [WIDTH-1:0] o_rd_mask
);

  logic [WIDTH-1:0] r_val  [DEPTH];
  logic [WIDTH-1:0] r_mask [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      r_val[i_wr_addr]  <= i_wr_data;
      r_mask[i_wr_addr] <= i_wr_mask;
    end
  end

  assign o_rd_data = r_val[i_rd_addr];
  assign o_rd_mask = r_mask[i_rd_addr];

endmodule

// File: rtl/seq_match_monitor.sv
// In-order expected-value monitor: match_pulse follows obs_data by two cycles (sample + compare register).
// Per-entry timeout exists only with SEQ_MATCH_MONITOR_TIMEOUT_EN defined; otherwise fail is tied low.
module seq_match_monitor
  import seq_match_monitor_pkg::*;
#(
  parameter int  WIDTH  = 16,
  parameter int  DEPTH  = 16,
  parameter int  STABLE = 1,
  parameter int  TMO_W  = 24,
  localparam int AW     = $clog2(DEPTH),
  localparam int NW     = AW + 1
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             load_we,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] load_mask,
  input  logic [NW-1:0]    num_exp,
  input  logic             start,
  input  logic [TMO_W-1:0] timeout_lim,
  input  logic             obs_ready,
  input  logic [WIDTH-1:0] obs_data,
  output logic             busy,
  output logic             match_pulse,
  output logic [AW-1:0]    match_idx,
  output logic             pass,
  output logic             fail
);

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_s_data;
  logic              r_s_rdy;
  logic [AW-1:0]     r_idx, w_idx_nxt;
  logic [NW-1:0]     r_num, w_num_nxt;
  logic [STAB_W-1:0] r_stab, w_stab_nxt;
  logic              r_match_pulse, w_match_pulse_nxt;
  logic [AW-1:0]     r_match_idx, w_match_idx_nxt;

  logic [WIDTH-1:0]  w_exp_val, w_exp_mask;
  logic [NW-1:0]     w_num_sat;
  logic              w_busy, w_hit, w_match, w_last, w_tmo_hit;

  seq_match_exp_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .i_clock   (clock),
    .i_wr_en   (load_we && !w_busy),
    .i_wr_addr (load_addr),
    .i_wr_data (load_data),
    .i_wr_mask (load_mask),
    .i_rd_addr (r_idx),
    .o_rd_data (w_exp_val),
    .o_rd_mask (w_exp_mask)
  );

  assign w_busy    = (r_state == ARMED) || (r_state == CHECK);
  assign w_hit     = r_s_rdy && (((r_s_data ^ w_exp_val) & w_exp_mask) == '0);
  assign w_match   = w_busy && w_hit && (r_stab == STAB_W'(STABLE - 1));
  assign w_last    = ({1'b0, r_idx} == (r_num - NW'(1)));
  assign w_num_sat = (num_exp > NW'(DEPTH)) ? NW'(DEPTH) : num_exp;

`ifdef SEQ_MATCH_MONITOR_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;

  // Budget is per entry: each consumed entry restarts the count.
  assign w_tmo_hit = w_busy && (timeout_lim != '0) &&
                     (({1'b0, r_tmo} + (TMO_W+1)'(1)) == {1'b0, timeout_lim});

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_tmo <= '0;
    end else if (start || w_match) begin
      r_tmo <= '0;
    end else if (w_busy) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^timeout_lim;
  assign w_tmo_hit    = 1'b0;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_num_nxt         = r_num;
    w_stab_nxt        = r_stab;
    w_match_pulse_nxt = 1'b0;
    w_match_idx_nxt   = r_match_idx;
    if (start) begin
      w_idx_nxt       = '0;
      w_stab_nxt      = '0;
      w_num_nxt       = w_num_sat;
      w_match_idx_nxt = '0;
      w_state_nxt     = (w_num_sat == '0) ? PASS : ARMED;
    end else begin
      unique case (r_state)
        // ARMED compares too, so the first entry sees the same two-cycle latency as later ones.
        ARMED, CHECK: begin
          if (w_match) begin
            w_match_pulse_nxt = 1'b1;
            w_match_idx_nxt   = r_idx;
            w_stab_nxt        = '0;
            if (w_last) begin
              w_state_nxt = PASS;
            end else begin
              w_idx_nxt   = r_idx + AW'(1);
              w_state_nxt = CHECK;
            end
          end else begin
            w_stab_nxt = w_hit ? (r_stab + STAB_W'(1)) : '0;
            if (w_tmo_hit) begin
              w_state_nxt = FAIL;
            end else if ((r_state == ARMED) && r_s_rdy) begin
              w_state_nxt = CHECK;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state       <= IDLE;
      r_s_data      <= '0;
      r_s_rdy       <= 1'b0;
      r_idx         <= '0;
      r_num         <= '0;
      r_stab        <= '0;
      r_match_pulse <= 1'b0;
      r_match_idx   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_s_data      <= obs_data;
      r_s_rdy       <= obs_ready;
      r_idx         <= w_idx_nxt;
      r_num         <= w_num_nxt;
      r_stab        <= w_stab_nxt;
      r_match_pulse <= w_match_pulse_nxt;
      r_match_idx   <= w_match_idx_nxt;
    end
  end

  assign busy        = w_busy;
  assign match_pulse = r_match_pulse;
  assign match_idx   = r_match_idx;
  assign pass        = (r_state == PASS);
`ifdef SEQ_MATCH_MONITOR_TIMEOUT_EN
  assign fail        = (r_state == FAIL);
`else
  assign fail        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_match_monitor.sv
// Bench for seq_match_monitor: two instances (STABLE=1 and STABLE=2) share one stimulus stream
// and are compared every cycle against a list-walking reference model, plus directed checks.
module tb_seq_match_monitor;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;
`ifdef SEQ_MATCH_MONITOR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          resetb = 1'b0;
  logic          load_we = 1'b0;
  logic          start = 1'b0;
  logic          obs_ready = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [W-1:0]  load_data = '0;
  logic [W-1:0]  load_mask = '0;
  logic [W-1:0]  obs_data = '0;
  logic [AW:0]   num_exp = '0;
  logic [23:0]   timeout_lim = '0;

  logic [1:0]    busy_w, pulse_w, pass_w, fail_w;
  logic [AW-1:0] midx_w [2];

  int n_asrt = 0;
  int n_fail = 0;
  int pc [2];

  always #5 clock = ~clock;

  seq_match_monitor #(.WIDTH(W), .DEPTH(D), .STABLE(1), .TMO_W(24)) u_dut (
    .clock(clock), .resetb(resetb), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .load_mask(load_mask), .num_exp(num_exp), .start(start),
    .timeout_lim(timeout_lim), .obs_ready(obs_ready), .obs_data(obs_data),
    .busy(busy_w[0]), .match_pulse(pulse_w[0]), .match_idx(midx_w[0]),
    .pass(pass_w[0]), .fail(fail_w[0])
  );

  seq_match_monitor #(.WIDTH(W), .DEPTH(D), .STABLE(2), .TMO_W(24)) u_dut2 (
    .clock(clock), .resetb(resetb), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .load_mask(load_mask), .num_exp(num_exp), .start(start),
    .timeout_lim(timeout_lim), .obs_ready(obs_ready), .obs_data(obs_data),
    .busy(busy_w[1]), .match_pulse(pulse_w[1]), .match_idx(midx_w[1]),
    .pass(pass_w[1]), .fail(fail_w[1])
  );

  // Reference model: walks the expected list, counting the current run of hits per entry.
  logic [W-1:0] mv [2][D];
  logic [W-1:0] mm [2][D];
  bit           m_act [2], m_pass [2], m_fail [2], m_pulse [2];
  int           m_idx [2], m_pos [2], m_run [2], m_tmo [2], m_num [2];
  logic [W-1:0] m_sd;
  logic         m_sr;
  bit           m_was, m_hit;
  int           m_n;

  always @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_pulse[k] = 0;
        m_idx[k] = 0; m_pos[k] = 0; m_run[k] = 0; m_tmo[k] = 0; m_num[k] = 0;
      end
      m_sd = '0;
      m_sr = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_was = m_act[k];
        m_pulse[k] = 0;
        m_n = (int'(num_exp) > D) ? D : int'(num_exp);
        if (start) begin
          m_pos[k] = 0; m_run[k] = 0; m_tmo[k] = 0; m_idx[k] = 0; m_fail[k] = 0;
          m_num[k] = m_n; m_pass[k] = (m_n == 0); m_act[k] = (m_n != 0);
        end else if (m_act[k]) begin
          m_hit = m_sr && (((m_sd ^ mv[k][m_pos[k]]) & mm[k][m_pos[k]]) == '0);
          m_run[k] = m_hit ? m_run[k] + 1 : 0;
          if (m_run[k] >= k + 1) begin
            m_pulse[k] = 1; m_idx[k] = m_pos[k]; m_run[k] = 0; m_tmo[k] = 0;
            if (m_pos[k] == m_num[k] - 1) begin
              m_pass[k] = 1; m_act[k] = 0;
            end else begin
              m_pos[k] = m_pos[k] + 1;
            end
          end else if (TMO_EN && timeout_lim != 0 && m_tmo[k] + 1 == int'(timeout_lim)) begin
            m_fail[k] = 1; m_act[k] = 0;
          end else begin
            m_tmo[k] = m_tmo[k] + 1;
          end
        end
        if (load_we && !m_was) begin
          mv[k][load_addr] = load_data;
          mm[k][load_addr] = load_mask;
        end
      end
      m_sd = obs_data;
      m_sr = obs_ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 2; k++) begin
      chk(k == 0 ? "busy0"  : "busy1",  32'(busy_w[k]),  32'(m_act[k]));
      chk(k == 0 ? "pulse0" : "pulse1", 32'(pulse_w[k]), 32'(m_pulse[k]));
      chk(k == 0 ? "midx0"  : "midx1",  32'(midx_w[k]),  32'(m_idx[k]));
      chk(k == 0 ? "pass0"  : "pass1",  32'(pass_w[k]),  32'(m_pass[k]));
      chk(k == 0 ? "fail0"  : "fail1",  32'(fail_w[k]),  32'(m_fail[k]));
      pc[k] += int'(pulse_w[k]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      cmp_all();
    end
  endtask

  task automatic load(input int a, input logic [W-1:0] v, input logic [W-1:0] m);
    load_we = 1'b1; load_addr = AW'(a); load_data = v; load_mask = m;
    step(1);
    load_we = 1'b0;
  endtask

  task automatic arm(input int n);
    num_exp = 5'(n); start = 1'b1;
    step(1);
    start = 1'b0;
    pc[0] = 0; pc[1] = 0;
  endtask

  logic [W-1:0] pool  [4] = '{16'h1111, 16'h2222, 16'h1122, 16'h2211};
  logic [W-1:0] mpool [4] = '{16'hFFFF, 16'hFF00, 16'h00FF, 16'hFFFF};

  initial begin
    // Reset state
    step(3);
    chk("rst_busy", 32'(busy_w[0]), 0);
    chk("rst_pass", 32'(pass_w[0]), 0);
    chk("rst_midx", 32'(midx_w[1]), 0);
    resetb = 1'b1;
    step(1);

    // Saturated num_exp over a full list of identical values
    for (int a = 0; a < D; a++) load(a, 16'h7777, 16'hFFFF);
    obs_data = 16'h0000; obs_ready = 1'b1;
    arm(31);
    obs_data = 16'h7777;
    step(40);
    chk("sat_pulses0", 32'(pc[0]), 16);
    chk("sat_pulses1", 32'(pc[1]), 16);
    chk("sat_midx0", 32'(midx_w[0]), 15);
    chk("sat_pass1", 32'(pass_w[1]), 1);

    // num_exp=0 passes immediately without a pulse
    arm(0);
    chk("zero_pass", 32'(pass_w[0]), 1);
    chk("zero_busy", 32'(busy_w[0]), 0);
    step(2);
    chk("zero_pulses", 32'(pc[0]), 0);

    // Basic three-entry sequence
    load(0, 16'h449A, 16'hFFFF); load(1, 16'h3042, 16'hFFFF); load(2, 16'h491E, 16'hFFFF);
    obs_data = 16'h0000;
    arm(3);
    obs_data = 16'h449A; step(3);
    obs_data = 16'h3042; step(3);
    obs_data = 16'h491E; step(3);
    chk("seq_pulses0", 32'(pc[0]), 3);
    chk("seq_midx0", 32'(midx_w[0]), 2);
    chk("seq_pass0", 32'(pass_w[0]), 1);
    chk("seq_pass1", 32'(pass_w[1]), 1);
    chk("seq_fail0", 32'(fail_w[0]), 0);

    // Asynchronous reset clears sticky outputs at once
    #2 resetb = 1'b0;
    #1;
    chk("arst_pass", 32'(pass_w[0]), 0);
    chk("arst_midx", 32'(midx_w[0]), 0);
    @(negedge clock);
    resetb = 1'b1;
    step(1);

    // Repeated expected value: one entry per cycle, STABLE counted afresh
    load(0, 16'h449A, 16'hFFFF); load(1, 16'h449A, 16'hFFFF);
    obs_data = 16'h0000;
    arm(2);
    obs_data = 16'h449A; step(2);
    obs_data = 16'h0000; step(1);
    chk("rep_pulses0", 32'(pc[0]), 2);
    chk("rep_pass0", 32'(pass_w[0]), 1);
    chk("rep_pass1_short", 32'(pass_w[1]), 0);
    arm(2);
    obs_data = 16'h449A; step(3);
    obs_data = 16'h0000; step(4);
    chk("rep3_pass1", 32'(pass_w[1]), 0);
    chk("rep3_busy1", 32'(busy_w[1]), 1);
    arm(2);
    obs_data = 16'h449A; step(4);
    obs_data = 16'h0000; step(3);
    chk("rep4_pass1", 32'(pass_w[1]), 1);

    // Masked compare
    load(0, 16'h475D, 16'hFF00);
    arm(1);
    obs_data = 16'h465D; step(4);
    chk("mask_nomatch", 32'(pass_w[0]), 0);
    obs_data = 16'h47AA; step(3);
    chk("mask_match", 32'(pass_w[0]), 1);

    // obs_ready gating and two-cycle latency
    load(0, 16'h5CB0, 16'hFFFF);
    obs_data = 16'h5CB0; obs_ready = 1'b0;
    arm(1);
    step(4);
    chk("rdy_low_pulses", 32'(pc[0]), 0);
    obs_ready = 1'b1;
    step(1);
    chk("rdy_lat1", 32'(pulse_w[0]), 0);
    step(1);
    chk("rdy_lat2", 32'(pulse_w[0]), 1);
    chk("rdy_pass", 32'(pass_w[0]), 1);

    // Restart mid-check; a load while busy must be ignored
    load(0, 16'h1234, 16'hFFFF); load(1, 16'h5678, 16'hFFFF); load(2, 16'h9ABC, 16'hFFFF);
    obs_data = 16'h0000;
    arm(3);
    obs_data = 16'h1234; step(2);
    obs_data = 16'h5678; step(2);
    obs_data = 16'h0000; step(2);
    chk("rst_mid_idx_before", 32'(midx_w[0]), 1);
    arm(3);
    chk("restart_midx", 32'(midx_w[0]), 0);
    chk("restart_busy", 32'(busy_w[0]), 1);
    load(0, 16'hDEAD, 16'hFFFF);
    obs_data = 16'h9ABC; step(4);
    chk("restart_no_e2", 32'(pc[0]), 0);
    obs_data = 16'h1234; step(3);
    chk("restart_e0", 32'(pc[0]), 1);
    chk("restart_e0_idx", 32'(midx_w[0]), 0);

    // Timeout: fail exactly 100 cycles after arming, or wait forever without the feature
    load(0, 16'h5CB0, 16'hFFFF);
    obs_data = 16'h0000; timeout_lim = 24'd100;
    arm(1);
    step(99);
    chk("tmo_99", 32'(fail_w[0]), 0);
    step(1);
    chk("tmo_100_fail", 32'(fail_w[0]), 32'(TMO_EN));
    chk("tmo_100_busy", 32'(busy_w[0]), 32'(!TMO_EN));
    step(9900);
    chk("tmo_long_busy", 32'(busy_w[1]), 32'(!TMO_EN));
    timeout_lim = 24'd0;

    // Randomized traffic against the model
    for (int a = 0; a < D; a++) load(a, pool[a % 4], mpool[a % 4]);
    for (int c = 0; c < 2000; c++) begin
      load_we   = ($urandom_range(0, 7) == 0);
      load_addr = AW'($urandom_range(0, D - 1));
      load_data = pool[$urandom_range(0, 3)];
      load_mask = mpool[$urandom_range(0, 3)];
      if ($urandom_range(0, 2) == 0) obs_data = pool[$urandom_range(0, 3)];
      obs_ready   = ($urandom_range(0, 4) != 0);
      start       = ($urandom_range(0, 29) == 0);
      num_exp     = 5'($urandom_range(0, 20));
      timeout_lim = ($urandom_range(0, 1) == 0) ? 24'd0 : 24'($urandom_range(5, 40));
      step(1);
    end
    load_we = 1'b0; start = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
